// File: rtl/fir_deconv_if.sv
// Handshake bundle between the loopback source and the FIR deconvolver.
// The master drives the filtered sample; the slave returns the recovered sample and status.
interface fir_deconv_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
);
    logic signed [IN_W-1:0]  In;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OUT_W-1:0] Out;
    logic                    out_valid;
    logic                    sat_err;

    modport master (
        output In, in_valid,
        input  in_ready, Out, out_valid, sat_err
    );

    modport slave (
        input  In, in_valid,
        output in_ready, Out, out_valid, sat_err
    );
endinterface

// File: rtl/fir_deconv.sv
// Inverse of the lab FIR: recovers x[n] = y[n] - sum h[k]*x[n-k] with a serial
// shift-and-add MAC, one tap per cycle, nine cycles per sample.
module fir_deconv #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4,
    parameter int ACC_W = 20
) (
    input  logic        clk,
    input  logic        rst,
    fir_deconv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              tapIdx_q, tapIdx_d;
    logic signed [OUT_W-1:0] hist_q [7];
    logic signed [OUT_W-1:0] hist_d [7];
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    outValid_q, outValid_d;
    logic                    satErr_q, satErr_d;

    logic signed [ACC_W-1:0] tapTerm;
    logic signed [OUT_W-1:0] satValue;
    logic                    overRange;

    function automatic logic signed [ACC_W-1:0] sextHist(input logic signed [OUT_W-1:0] v);
        return {{(ACC_W - OUT_W){v[OUT_W-1]}}, v};
    endfunction

    // Coefficients are +/- powers of two, so each tap is a shift with the sign folded into add/sub.
    always_comb begin
        tapTerm = '0;
        case (tapIdx_q)
            3'd1:    tapTerm = -(sextHist(hist_q[0]) <<< 2);
            3'd2:    tapTerm = -(sextHist(hist_q[1]) <<< 4);
            3'd3:    tapTerm = -(sextHist(hist_q[2]) <<< 6);
            3'd4:    tapTerm =   sextHist(hist_q[3]) <<< 6;
            3'd5:    tapTerm =   sextHist(hist_q[4]) <<< 4;
            3'd6:    tapTerm =   sextHist(hist_q[5]) <<< 2;
            3'd7:    tapTerm =   sextHist(hist_q[6]);
            default: tapTerm = '0;
        endcase
    end

    always_comb begin
        overRange = (acc_q > SAT_MAX) || (acc_q < SAT_MIN);
        if (acc_q > SAT_MAX) begin
            satValue = SAT_MAX[OUT_W-1:0];
        end else if (acc_q < SAT_MIN) begin
            satValue = SAT_MIN[OUT_W-1:0];
        end else begin
            satValue = acc_q[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tapIdx_d   = tapIdx_q;
        out_d      = out_q;
        outValid_d = 1'b0;
        satErr_d   = satErr_q;
        for (int i = 0; i < 7; i++) begin
            hist_d[i] = hist_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d    = {{(ACC_W - IN_W){bus.In[IN_W-1]}}, bus.In};
                    tapIdx_d = 3'd1;
                    state_d  = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + tapTerm;
                if (tapIdx_q == 3'd7) begin
                    state_d = OUT;
                end else begin
                    tapIdx_d = tapIdx_q + 3'd1;
                end
            end
            OUT: begin
                // History keeps the clamped value so later taps see what was actually emitted.
                out_d      = satValue;
                outValid_d = 1'b1;
                satErr_d   = satErr_q | overRange;
                hist_d[0]  = satValue;
                for (int i = 1; i < 7; i++) begin
                    hist_d[i] = hist_q[i-1];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            tapIdx_q   <= '0;
            out_q      <= '0;
            outValid_q <= 1'b0;
            satErr_q   <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tapIdx_q   <= tapIdx_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            satErr_q   <= satErr_d;
            for (int i = 0; i < 7; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.Out       = out_q;
    assign bus.out_valid = outValid_q;
    assign bus.sat_err   = satErr_q;
endmodule

// File: tb/tb_fir_deconv.sv
// Bench for fir_deconv: a recursion-level model predicts every output cycle,
// and directed sequences pin the model with hand-computed values.
module tb_fir_deconv;
    localparam int IN_W  = 16;
    localparam int OUT_W = 4;
    localparam int ACC_W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fir_deconv_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    fir_deconv #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int hCoef [8] = '{1, 4, 16, 64, -64, -16, -4, -1};
    int hist [7];
    int lastOut;
    bit satFlag;
    int readyAt;
    int dueAt;
    bit pendingValid;
    int pendingX;
    bit pendingSat;
    bit checking = 1'b0;
    bit expValid;
    int seen [$];

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int clampX(input int a);
        if (a > 7) return 7;
        if (a < -8) return -8;
        return a;
    endfunction

    function automatic void modelReset();
        foreach (hist[i]) hist[i] = 0;
        lastOut      = 0;
        satFlag      = 1'b0;
        readyAt      = 0;
        dueAt        = 0;
        pendingValid = 1'b0;
        pendingX     = 0;
        pendingSat   = 1'b0;
    endfunction

    // Direct evaluation of the recursion; the result becomes visible nine cycles later.
    function automatic void modelAccept(input int y);
        int acc;
        acc = y;
        for (int k = 1; k < 8; k++) acc -= hCoef[k] * hist[k-1];
        pendingX   = clampX(acc);
        pendingSat = (acc > 7) || (acc < -8);
        for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
        hist[0]      = pendingX;
        pendingValid = 1'b1;
        dueAt        = cycle + 9;
        readyAt      = cycle + 9;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            expValid = pendingValid && (cycle == dueAt);
            if (expValid) begin
                lastOut      = pendingX;
                satFlag      = satFlag | pendingSat;
                pendingValid = 1'b0;
            end
            checkOutput("in_ready", int'(bus.in_ready), int'(cycle >= readyAt));
            checkOutput("out_valid", int'(bus.out_valid), int'(expValid));
            checkOutput("Out", int'(bus.Out), lastOut);
            checkOutput("sat_err", int'(bus.sat_err), int'(satFlag));
            if (bus.out_valid === 1'b1) seen.push_back(int'(bus.Out));
        end
        if (rst) begin
            modelReset();
            checking = 1'b1;
        end else if (checking && bus.in_valid && cycle >= readyAt) begin
            modelAccept(int'(bus.In));
        end
    end

    task automatic applyStimulus(input int y);
        int waitCnt;
        @(posedge clk);
        #1;
        bus.In       = IN_W'(y);
        bus.in_valid = 1'b1;
        waitCnt      = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waitCnt < 30) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("handshake", int'(bus.in_ready === 1'b1), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (pendingValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", int'(pendingValid), 0);
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic runSeq(input string name, input int ys[$], input int exp[$]);
        seen.delete();
        foreach (ys[i]) applyStimulus(ys[i]);
        waitDrain();
        checkOutput({name, "_count"}, seen.size(), exp.size());
        foreach (exp[i]) begin
            checkOutput($sformatf("%s[%0d]", name, i), (i < seen.size()) ? seen[i] : -999, exp[i]);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ys [$];
        int exp [$];
        int xs [$];
        int y;

        bus.In       = '0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_Out", int'(bus.Out), 0);
        checkOutput("reset_sat_err", int'(bus.sat_err), 0);

        ys  = '{1, 4, 16, 64, -64, -16, -4, -1, 0};
        exp = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        runSeq("impulse", ys, exp);
        checkOutput("impulse_sat_err", int'(bus.sat_err), 0);

        ys  = '{1, 5, 21, 85, 21, 5, 1, 0, 0};
        exp = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        runSeq("const_p1", ys, exp);

        doReset();
        ys  = '{-8, -40, -168, -680, -168, -40, -8, 0};
        exp = '{-8, -8, -8, -8, -8, -8, -8, -8};
        runSeq("const_m8", ys, exp);
        checkOutput("const_m8_sat_err", int'(bus.sat_err), 0);

        // 100 clamps to 7; then 0 - 4*7 = -28 clamps to -8.
        doReset();
        ys  = '{100, 0};
        exp = '{7, -8};
        runSeq("saturate", ys, exp);
        checkOutput("saturate_sat_err", int'(bus.sat_err), 1);

        // Holding in_valid high: only IDLE cycles accept, so 45 cycles yield exactly 5 samples.
        doReset();
        seen.delete();
        @(posedge clk);
        #1;
        bus.In       = IN_W'(1);
        bus.in_valid = 1'b1;
        repeat (45) @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitDrain();
        exp = '{1, -3, -3, -3, 7};
        checkOutput("busy_count", seen.size(), 5);
        foreach (exp[i]) begin
            checkOutput($sformatf("busy[%0d]", i), (i < seen.size()) ? seen[i] : -999, exp[i]);
        end

        // Reset lands on the third ACC cycle of an in-flight sample; sat_err is already set here.
        applyStimulus(5);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready", int'(bus.in_ready), 1);
        checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
        checkOutput("midrst_Out", int'(bus.Out), 0);
        checkOutput("midrst_sat_err", int'(bus.sat_err), 0);
        ys  = '{1};
        exp = '{1};
        runSeq("midrst_after", ys, exp);

        // Filter random 4-bit symbols forward, then expect the exact symbols back.
        doReset();
        seen.delete();
        xs.delete();
        for (int n = 0; n < 40; n++) begin
            xs.push_back(int'($urandom_range(0, 15)) - 8);
            y = 0;
            for (int k = 0; k < 8; k++) begin
                if (n - k >= 0) y += hCoef[k] * xs[n-k];
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus(y);
        end
        waitDrain();
        checkOutput("roundtrip_count", seen.size(), 40);
        foreach (xs[i]) begin
            checkOutput($sformatf("roundtrip[%0d]", i), (i < seen.size()) ? seen[i] : -999, xs[i]);
        end
        checkOutput("roundtrip_sat_err", int'(bus.sat_err), 0);

        // Unconstrained y exercises saturation paths; the per-cycle model does the checking.
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            applyStimulus(int'($urandom_range(0, 6000)) - 3000);
        end
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
